// File: rtl/i2c_tx_fifo.sv
// Transmit FIFO feeding the I2C master core: show-ahead head byte, occupancy and threshold flags.
// Optional sticky overflow/underflow flags are built when I2C_TX_FIFO_ERR_FLAGS_EN is defined.
module i2c_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  i2c_core_clock_i,
  input  logic                  reset_bit_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic                  flush_i,
  input  logic                  clear_flags_i,
  input  logic [ADDR_WIDTH-1:0] thresh_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PtrOne = 1;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic                  wr_accept, rd_accept;

  // Status derives only from registered pointers, never from this cycle's enables.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign almost_empty_o = (count_o <= {1'b0, thresh_i});
  assign rd_data_o = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

  // A pop frees the slot a simultaneous push needs, so full does not block a paired write.
  assign wr_accept = wr_en_i & (~full_o | rd_en_i) & ~flush_i;
  assign rd_accept = rd_en_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + PtrOne;
      if (rd_accept) rd_ptr_d = rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge i2c_core_clock_i or posedge reset_bit_i) begin
    if (reset_bit_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i2c_core_clock_i) begin
    if (wr_accept) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data_i;
  end

`ifdef I2C_TX_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;
  logic ovf_evt, unf_evt;

  assign ovf_evt = wr_en_i & full_o & ~rd_en_i & ~flush_i;
  assign unf_evt = rd_en_i & empty_o & ~flush_i;

  // A new error in the same cycle as a clear wins.
  always_comb begin
    overflow_d  = (overflow_q & ~clear_flags_i) | ovf_evt;
    underflow_d = (underflow_q & ~clear_flags_i) | unf_evt;
  end

  always_ff @(posedge i2c_core_clock_i or posedge reset_bit_i) begin
    if (reset_bit_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`else
  logic unused_clear_flags;
  assign unused_clear_flags = clear_flags_i;
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

endmodule

// File: doc/i2c_tx_fifo.md
# i2c_tx_fifo

Transmit FIFO sitting directly upstream of the I2C master core. It buffers bytes written by the CPU/register interface and presents the head byte on a show-ahead output, which feeds the master's transmit data input. Its empty flag drives the master's transmit-FIFO-empty input, and the master's FIFO read-enable pops it. It also provides an occupancy count, an almost-empty threshold flag, and optional sticky error flags.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width.
- ADDR_WIDTH, 4, pointer width; depth = 2^ADDR_WIDTH (16).

Ports:
- i2c_core_clock_i  in  1  core clock; all state updates on rising edge.
- reset_bit_i  in  1  reset, asynchronous and active-high.
- wr_en_i  in  1  push wr_data_i this cycle (CPU side).
- wr_data_i  in  DATA_WIDTH  byte to push.
- rd_en_i  in  1  pop head byte; driven by the master's FIFO read-enable.
- flush_i  in  1  synchronous clear of contents (pointers only).
- clear_flags_i  in  1  clears sticky error flags.
- thresh_i  in  ADDR_WIDTH  almost-empty threshold.
- rd_data_o  out  DATA_WIDTH  head byte, show-ahead; feeds master data input.
- empty_o  out  1  no valid entries; feeds master trans_fifo_empty input.
- full_o  out  1  2^ADDR_WIDTH entries held.
- count_o  out  ADDR_WIDTH+1  current occupancy, 0..2^ADDR_WIDTH.
- almost_empty_o  out  1  count_o <= thresh_i.
- overflow_o  out  1  sticky: write attempted while full.
- underflow_o  out  1  sticky: read attempted while empty.

## Operation
- Storage: 2^ADDR_WIDTH x DATA_WIDTH register array. Write and read pointers are each ADDR_WIDTH+1 bits, with the MSB used as a wrap bit.
- count_o = wr_ptr - rd_ptr, computed modulo 2^(ADDR_WIDTH+1).
- empty_o = (wr_ptr == rd_ptr).
- full_o = low ADDR_WIDTH bits equal and MSBs differ.
- Write accepted when wr_en_i & (~full_o | rd_en_i). Array is written at wr_ptr[ADDR_WIDTH-1:0], then wr_ptr increments.
- Read accepted when rd_en_i & ~empty_o. rd_ptr increments.
- rd_data_o = mem[rd_ptr[ADDR_WIDTH-1:0]], a combinational read of the registered array. When empty, rd_data_o holds the stale entry and is don't-care.
- Simultaneous events:
  - Read+write while full: both accepted; count unchanged; no overflow.
  - Read+write while empty: write accepted; read rejected and flags underflow. The written byte is not visible until the next cycle.
  - Read+write otherwise: both accepted; count unchanged.
- Flush has priority over wr_en_i and rd_en_i in the same cycle. Both pointers go to 0 and nothing is written. Sticky flags are unaffected.
- Flag priority: clear_flags_i clears the flags, but a new error in the same cycle sets them (set wins).
- Pointer wrap: pointers wrap naturally at 2^(ADDR_WIDTH+1), and the array index wraps at depth. There is no special-casing.
- thresh_i = 0: almost_empty_o equals empty_o.
- Reset mid-operation: pointers and flags go to 0 immediately (asynchronously). Array contents are not cleared.

## Timing
- Reset values: empty_o=1, full_o=0, count_o=0, almost_empty_o=1, overflow_o=0, underflow_o=0. rd_data_o is undefined until the first write.
- Write latency: a byte pushed at edge N is visible on rd_data_o, with empty_o=0, after edge N (one cycle).
- Pop latency: after the popping edge, rd_data_o shows the next entry in the same cycle as the updated count.
- All status outputs derive from registered pointers/flags only. There is no combinational path from wr_en_i or rd_en_i to any output.
- Error flags assert the cycle after the offending edge and stay asserted until cleared or reset.
- Full throughput: one push and one pop per cycle.

## Configuration
- I2C_TX_FIFO_ERR_FLAGS_EN defined: overflow_o and underflow_o are implemented as described, and clear_flags_i is honoured.
- Not defined: overflow_o and underflow_o are tied to 0, no flag registers exist, and clear_flags_i is ignored. Write/read acceptance rules are identical in both builds.

## Test plan
- Reset, then push 0xA5: next cycle empty_o=0, count_o=1, rd_data_o=0xA5. Pop it: empty_o=1, count_o=0.
- Push 0x00..0x0F (16 bytes): full_o=1, count_o=16. Push 0xFF while full: it is dropped, overflow_o=1 (macro on). Pop all 16: data order 0x00..0x0F, then empty_o=1.
- At full, assert wr_en_i=1 (0x55) and rd_en_i=1 together: count_o stays 16, and 0x55 appears as the 16th pop. At empty, assert both: count_o=1 and underflow_o=1.
- Run 40 push/pop pairs with count held at 3, so the pointers wrap: data order is preserved, and there is no false full_o/empty_o.
- Set thresh_i=2: almost_empty_o=1 at counts 0..2 and 0 at count 3. Assert flush_i with wr_en_i at count 5: count_o=0 and empty_o=1. Assert clear_flags_i: flags go to 0.
- Assert reset_bit_i asynchronously mid-burst at count 7: outputs return to reset values without waiting for a clock edge.
